// File: rtl/code_maker.sv
// Code-maker side of the Mastermind datapath.
// Captures a 4-symbol secret from SW (one symbol per button press), publishes it
// on R1, then scores each accepted 12-bit guess sequentially: four cycles of
// positional compare followed by eight cycles of per-colour occurrence counting.
module code_maker (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  SW,
   input  logic        enterMaker,
   input  logic        new_round,
   input  logic [11:0] guess,
   input  logic        guess_valid,
   output logic [11:0] R1,
   output logic        code_ready,
   output logic        guess_ready,
   output logic        fb_valid,
   output logic [2:0]  exact,
   output logic [2:0]  partial,
   output logic        win
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTER,
      S_LOCKED,
      S_SCORE_EX,
      S_SCORE_COL,
      S_RESP,
      S_SOLVED
   } state_t;

   state_t      state_reg;
   logic [11:0] r1_reg;
   logic [11:0] guess_reg;
   logic        enter_sync_reg;
   logic        enter_prev_reg;
   logic [2:0]  entry_cnt_reg;
   logic [1:0]  pos_reg;
   logic [2:0]  col_reg;
   logic [2:0]  exact_acc_reg;
   logic [2:0]  sum_reg;
   logic [2:0]  exact_reg;
   logic [2:0]  partial_reg;
   logic        code_ready_reg;
   logic        guess_ready_reg;
   logic        fb_valid_reg;
   logic        win_reg;

   // Combinational helpers for scoring
   logic        enter_rise;
   logic [2:0]  code_sym  [0:3];
   logic [2:0]  guess_sym [0:3];
   logic [3:0]  pos_eq;
   logic [3:0]  code_hit;
   logic [3:0]  guess_hit;
   logic [2:0]  code_cnt;
   logic [2:0]  guess_cnt;
   logic [2:0]  col_min;
   logic [2:0]  sum_next;
   logic        pos_match;

   assign enter_rise = enter_sync_reg & ~enter_prev_reg;

   // Split code and captured guess into symbols; symbol i lives at bits [3i+2:3i]
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sym
         assign code_sym[gi]  = r1_reg[3*gi +: 3];
         assign guess_sym[gi] = guess_reg[3*gi +: 3];
         assign pos_eq[gi]    = (code_sym[gi] == guess_sym[gi]);
         assign code_hit[gi]  = (code_sym[gi] == col_reg);
         assign guess_hit[gi] = (guess_sym[gi] == col_reg);
      end
   endgenerate

   assign pos_match = pos_eq[pos_reg];
   assign code_cnt  = {2'b00, code_hit[0]}  + {2'b00, code_hit[1]}
                    + {2'b00, code_hit[2]}  + {2'b00, code_hit[3]};
   assign guess_cnt = {2'b00, guess_hit[0]} + {2'b00, guess_hit[1]}
                    + {2'b00, guess_hit[2]} + {2'b00, guess_hit[3]};
   // Colour-correct hits for this colour are bounded by the scarcer side
   assign col_min   = (code_cnt < guess_cnt) ? code_cnt : guess_cnt;
   assign sum_next  = sum_reg + col_min;

   // Button level sampling for rising-edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enter_sync_reg <= 1'b0;
         enter_prev_reg <= 1'b0;
      end else begin
         enter_sync_reg <= enterMaker;
         enter_prev_reg <= enter_sync_reg;
      end
   end

   // Main controller: entry, lock, sequential scoring and response with registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= S_IDLE;
         r1_reg          <= 12'd0;
         guess_reg       <= 12'd0;
         entry_cnt_reg   <= 3'd0;
         pos_reg         <= 2'd0;
         col_reg         <= 3'd0;
         exact_acc_reg   <= 3'd0;
         sum_reg         <= 3'd0;
         exact_reg       <= 3'd0;
         partial_reg     <= 3'd0;
         code_ready_reg  <= 1'b0;
         guess_ready_reg <= 1'b0;
         fb_valid_reg    <= 1'b0;
         win_reg         <= 1'b0;
      end else if (new_round) begin
         // A new round wins over everything else arriving in the same cycle
         state_reg       <= S_IDLE;
         r1_reg          <= 12'd0;
         entry_cnt_reg   <= 3'd0;
         pos_reg         <= 2'd0;
         col_reg         <= 3'd0;
         exact_acc_reg   <= 3'd0;
         sum_reg         <= 3'd0;
         exact_reg       <= 3'd0;
         partial_reg     <= 3'd0;
         code_ready_reg  <= 1'b0;
         guess_ready_reg <= 1'b0;
         fb_valid_reg    <= 1'b0;
         win_reg         <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (enter_rise) begin
                  r1_reg        <= {r1_reg[8:0], SW};
                  entry_cnt_reg <= 3'd1;
                  state_reg     <= S_ENTER;
               end
            end

            S_ENTER: begin
               if (enter_rise) begin
                  r1_reg        <= {r1_reg[8:0], SW};
                  entry_cnt_reg <= entry_cnt_reg + 3'd1;
                  if (entry_cnt_reg == 3'd3) begin
                     code_ready_reg  <= 1'b1;
                     guess_ready_reg <= 1'b1;
                     state_reg       <= S_LOCKED;
                  end
               end
            end

            S_LOCKED: begin
               // Button presses are ignored once the code is locked
               if (guess_valid) begin
                  guess_reg       <= guess;
                  exact_acc_reg   <= 3'd0;
                  sum_reg         <= 3'd0;
                  pos_reg         <= 2'd0;
                  col_reg         <= 3'd0;
                  guess_ready_reg <= 1'b0;
                  state_reg       <= S_SCORE_EX;
               end
            end

            S_SCORE_EX: begin
               if (pos_match) begin
                  exact_acc_reg <= exact_acc_reg + 3'd1;
               end
               pos_reg <= pos_reg + 2'd1;
               if (pos_reg == 2'd3) begin
                  state_reg <= S_SCORE_COL;
               end
            end

            S_SCORE_COL: begin
               sum_reg <= sum_next;
               col_reg <= col_reg + 3'd1;
               if (col_reg == 3'd7) begin
                  // Total colour hits include the exact ones; remove them for partial
                  exact_reg    <= exact_acc_reg;
                  partial_reg  <= sum_next - exact_acc_reg;
                  fb_valid_reg <= 1'b1;
                  state_reg    <= S_RESP;
               end
            end

            S_RESP: begin
               fb_valid_reg <= 1'b0;
               if (exact_reg == 3'd4) begin
                  win_reg   <= 1'b1;
                  state_reg <= S_SOLVED;
               end else begin
                  guess_ready_reg <= 1'b1;
                  state_reg       <= S_LOCKED;
               end
            end

            S_SOLVED: begin
               state_reg <= S_SOLVED;
            end

            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign R1          = r1_reg;
   assign code_ready  = code_ready_reg;
   assign guess_ready = guess_ready_reg;
   assign fb_valid    = fb_valid_reg;
   assign exact       = exact_reg;
   assign partial     = partial_reg;
   assign win         = win_reg;

endmodule

// File: tb/tb_code_maker.sv
// Scoreboard bench for code_maker: guesses push expected scores into a queue,
// an independent monitor pops and compares on every fb_valid pulse.
module tb_code_maker;

   logic        clk;
   logic        reset;
   logic [2:0]  SW;
   logic        enterMaker;
   logic        new_round;
   logic [11:0] guess;
   logic        guess_valid;
   logic [11:0] R1;
   logic        code_ready;
   logic        guess_ready;
   logic        fb_valid;
   logic [2:0]  exact;
   logic [2:0]  partial;
   logic        win;

   typedef struct {
      logic [2:0] ex;
      logic [2:0] pa;
      int         acc;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   failures;
   int   cyc;
   int   fb_seen;
   logic prev_fb;

   code_maker dut (
      .clk         (clk),
      .reset       (reset),
      .SW          (SW),
      .enterMaker  (enterMaker),
      .new_round   (new_round),
      .guess       (guess),
      .guess_valid (guess_valid),
      .R1          (R1),
      .code_ready  (code_ready),
      .guess_ready (guess_ready),
      .fb_valid    (fb_valid),
      .exact       (exact),
      .partial     (partial),
      .win         (win)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every response must be expected, correct, on edge 12, and one cycle wide
   always @(negedge clk) begin
      exp_t e;
      if (fb_valid === 1'b1) begin
         fb_seen++;
         check("fb_pulse_width", {31'd0, prev_fb}, 32'd0);
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_fb actual exact=%0d partial=%0d required=no response", exact, partial);
         end else begin
            e = q.pop_front();
            check("resp_exact", {29'd0, exact}, {29'd0, e.ex});
            check("resp_partial", {29'd0, partial}, {29'd0, e.pa});
            check("resp_latency", cyc - e.acc, 32'd12);
            $display("resp exact=%0d partial=%0d latency=%0d", exact, partial, cyc - e.acc);
         end
      end
      prev_fb <= fb_valid;
   end

   task automatic press(input logic [2:0] s);
      @(negedge clk);
      SW = s;
      enterMaker = 1'b1;
      repeat (2) @(negedge clk);
      enterMaker = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic enter_code(input logic [2:0] a, input logic [2:0] b,
                             input logic [2:0] c, input logic [2:0] d);
      press(a);
      press(b);
      press(c);
      press(d);
      $display("entered code R1=%o code_ready=%0b", R1, code_ready);
   endtask

   task automatic do_guess(input logic [11:0] g, input logic [2:0] ex,
                           input logic [2:0] pa, input bit push);
      exp_t e;
      @(negedge clk);
      for (int i = 0; i < 40 && guess_ready !== 1'b1; i++) @(negedge clk);
      if (guess_ready !== 1'b1) begin
         check("guess_ready_wait", {31'd0, guess_ready}, 32'd1);
      end else begin
         guess = g;
         guess_valid = 1'b1;
         @(posedge clk);
         #1;
         if (push) begin
            e.ex = ex;
            e.pa = pa;
            e.acc = cyc;
            q.push_back(e);
         end
         @(negedge clk);
         guess_valid = 1'b0;
         guess = 12'o7777;
         $display("guess %o accepted expect exact=%0d partial=%0d", g, ex, pa);
      end
   endtask

   task automatic wait_resp();
      for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         check("resp_timeout", q.size(), 32'd0);
         q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic pulse_new_round();
      @(negedge clk);
      new_round = 1'b1;
      @(negedge clk);
      new_round = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      failures = 0;
      cyc = 0;
      fb_seen = 0;
      prev_fb = 1'b0;
      reset = 1'b0;
      SW = 3'd0;
      enterMaker = 1'b0;
      new_round = 1'b0;
      guess = 12'd0;
      guess_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_R1", {20'd0, R1}, 32'd0);
      check("rst_code_ready", {31'd0, code_ready}, 32'd0);
      check("rst_guess_ready", {31'd0, guess_ready}, 32'd0);
      check("rst_fb_valid", {31'd0, fb_valid}, 32'd0);
      check("rst_exact_partial_win", {25'd0, exact, partial, win}, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Code entry and exact match
      enter_code(3'd1, 3'd2, 3'd3, 3'd4);
      check("entry_R1", {20'd0, R1}, 32'o1234);
      check("entry_code_ready", {31'd0, code_ready}, 32'd1);
      check("entry_guess_ready", {31'd0, guess_ready}, 32'd1);
      do_guess(12'o1234, 3'd4, 3'd0, 1'b1);
      wait_resp();
      check("solved_win", {31'd0, win}, 32'd1);
      check("solved_guess_ready", {31'd0, guess_ready}, 32'd0);
      repeat (5) @(negedge clk);
      check("solved_hold_guess_ready", {31'd0, guess_ready}, 32'd0);

      // new_round from SOLVED
      pulse_new_round();
      check("nr_R1", {20'd0, R1}, 32'd0);
      check("nr_win", {31'd0, win}, 32'd0);
      check("nr_code_ready", {31'd0, code_ready}, 32'd0);
      check("nr_exact_partial", {26'd0, exact, partial}, 32'd0);

      // Full permutation
      enter_code(3'd1, 3'd2, 3'd3, 3'd4);
      do_guess(12'o4321, 3'd0, 3'd4, 1'b1);
      wait_resp();
      check("perm_win", {31'd0, win}, 32'd0);
      check("perm_guess_ready", {31'd0, guess_ready}, 32'd1);

      // Duplicate colours
      pulse_new_round();
      enter_code(3'd1, 3'd1, 3'd2, 3'd3);
      check("dup_R1", {20'd0, R1}, 32'o1123);
      do_guess(12'o1111, 3'd2, 3'd0, 1'b1);
      wait_resp();
      do_guess(12'o3211, 3'd0, 3'd4, 1'b1);
      wait_resp();

      // Busy rejection: second guess offered during SCORE_COL must be dropped
      do_guess(12'o1111, 3'd2, 3'd0, 1'b1);
      repeat (5) @(negedge clk);
      guess = 12'o3211;
      guess_valid = 1'b1;
      @(negedge clk);
      guess_valid = 1'b0;
      wait_resp();
      repeat (20) @(negedge clk);
      check("busy_exact_hold", {29'd0, exact}, 32'd2);
      check("busy_partial_hold", {29'd0, partial}, 32'd0);
      check("busy_guess_ready", {31'd0, guess_ready}, 32'd1);

      // Held button counts once
      pulse_new_round();
      @(negedge clk);
      SW = 3'd5;
      enterMaker = 1'b1;
      repeat (5) @(negedge clk);
      enterMaker = 1'b0;
      repeat (3) @(negedge clk);
      check("held_R1", {20'd0, R1}, 32'o0005);
      check("held_code_ready", {31'd0, code_ready}, 32'd0);
      press(3'd6);
      press(3'd7);
      press(3'd0);
      check("held_full_R1", {20'd0, R1}, 32'o5670);
      press(3'd3);
      check("locked_ignore_press", {20'd0, R1}, 32'o5670);

      // Reset mid-score: outputs clear at once, no response ever appears
      do_guess(12'o5670, 3'd4, 3'd0, 1'b0);
      repeat (5) @(posedge clk);
      #4;
      reset = 1'b0;
      #1;
      check("abort_R1", {20'd0, R1}, 32'd0);
      check("abort_flags", {28'd0, code_ready, guess_ready, fb_valid, win}, 32'd0);
      check("abort_exact_partial", {26'd0, exact, partial}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (25) @(negedge clk);
      check("abort_idle_R1", {20'd0, R1}, 32'd0);
      check("fb_total", fb_seen, 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
